// File: rtl/load_store_unit.sv
// Load/store unit: turns one RV32I load/store request into word-wide data-memory
// accesses, with sub-word stores done as read-modify-write.
module load_store_unit #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_reg, state_next;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg, wdata_reg, rmw_word_reg, resp_rdata_reg;
  logic        resp_err_reg;

  logic        accept;
  logic        f3_ok, misaligned, out_of_range, req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, lane_data, merged_word;
  logic        mem_rd_state, mem_wr_state;

  assign req_ready = (state_reg == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Request decode, evaluated on the live request inputs in IDLE
  always_comb begin
    f3_ok = req_write ? (req_funct3 <= 3'd2)
                      : !(req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    out_of_range = {2'b00, req_addr[31:2]} >= DEPTH_W;
    req_err = !f3_ok || misaligned || out_of_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err)                 state_next = RESP;
          else if (!req_write)         state_next = RD;
          else if (req_funct3 == 3'd2) state_next = WR;
          else                         state_next = RMW_RD;
        end
      end
      RD:      state_next = RESP;
      WR:      state_next = RESP;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ld_byte = read_data[{addr_reg[1:0], 3'b000} +: 8];
    ld_half = addr_reg[1] ? read_data[31:16] : read_data[15:0];
    case (funct3_reg)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = read_data;
    endcase
  end

  // Store data replicated across lanes; only the enabled lanes replace the captured word
  assign lane_data = funct3_reg[0] ? {2{wdata_reg[15:0]}} : {4{wdata_reg[7:0]}};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic lane_en;
      assign lane_en = funct3_reg[0] ? (LANE[1] == addr_reg[1]) : (LANE == addr_reg[1:0]);
      assign merged_word[8*gi +: 8] = lane_en ? lane_data[8*gi +: 8] : rmw_word_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_reg     <= 3'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      rmw_word_reg   <= 32'd0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else if (accept) begin
      funct3_reg     <= req_funct3;
      addr_reg       <= req_addr;
      wdata_reg      <= req_wdata;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= req_err;
    end else begin
      case (state_reg)
        RD:     resp_rdata_reg <= ld_data;
        RMW_RD: rmw_word_reg   <= read_data;
        RESP: begin
          resp_rdata_reg <= 32'd0;
          resp_err_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_state = (state_reg == RD) || (state_reg == RMW_RD);
  assign mem_wr_state = (state_reg == WR) || (state_reg == RMW_WR);

  // Write enable is gated by rst so a write never lands on a reset edge
  always_comb begin
    MemRead    = mem_rd_state;
    MemWrite   = mem_wr_state && !rst;
    address    = (mem_rd_state || mem_wr_state) ? {2'b00, addr_reg[31:2]} : 32'd0;
    write_data = 32'd0;
    if (state_reg == WR)     write_data = wdata_reg;
    if (state_reg == RMW_WR) write_data = merged_word;
  end

  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached word memory plus a byte-level reference
// model; directed cases followed by randomized requests.
module tb_load_store_unit;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead, MemWrite;
  logic [31:0] address, write_data, read_data;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int tests_run = 0;
  int tests_failed = 0;
  int mw_edges = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  // Attached data memory: combinational read, write on rising edge
  assign read_data = (address < DEPTH) ? tb_mem[address[5:0]] : 32'd0;
  always @(posedge clk) begin
    if (MemWrite) begin
      mw_edges++;
      if (address < DEPTH) tb_mem[address[5:0]] <= write_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-address arithmetic on a word array
  task automatic ref_model(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output bit err, output logic [31:0] rdata,
                           output int lat, output logic [31:0] new_word);
    int size, shift;
    logic [31:0] mask, v;
    bit legal;
    legal = wr ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    err = 1; rdata = 0; lat = 1; new_word = 0;
    if (legal) begin
      size = 1 << f3[1:0];
      if ((addr % size) == 0 && (addr / 4) < DEPTH) begin
        err = 0;
        shift = 8 * (addr % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
        if (!wr) begin
          v = (ref_mem[addr / 4] >> shift) & mask;
          if (f3 < 4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
          rdata = v;
          lat = 2;
        end else begin
          ref_mem[addr / 4] = (ref_mem[addr / 4] & ~(mask << shift)) | ((wd & mask) << shift);
          new_word = ref_mem[addr / 4];
          lat = (size == 4) ? 2 : 3;
        end
      end
    end
  endtask

  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got_rdata);
    bit exp_err, saw_rd, saw_wr, both;
    logic [31:0] exp_rdata, exp_word, rd_addr, wr_addr, wr_data;
    logic err_got;
    int exp_lat, got_lat, w;
    ref_model(wr, f3, addr, wd, exp_err, exp_rdata, exp_lat, exp_word);
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check_val("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    saw_rd = 0; saw_wr = 0; both = 0; got_lat = 0; got_rdata = 0; err_got = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (MemRead)  begin saw_rd = 1; rd_addr = address; end
      if (MemWrite) begin saw_wr = 1; wr_addr = address; wr_data = write_data; end
      if (MemRead && MemWrite) both = 1;
      if (resp_valid) begin got_lat = n; got_rdata = resp_rdata; err_got = resp_err; break; end
    end
    check_val("latency", got_lat, exp_lat);
    check_val("resp_err", {31'd0, err_got}, {31'd0, exp_err});
    check_val("resp_rdata", got_rdata, exp_rdata);
    check_val("rd_wr_overlap", {31'd0, both}, 32'd0);
    if (exp_err) begin
      check_val("err_mem_access", {30'd0, saw_rd, saw_wr}, 32'd0);
    end else if (!wr) begin
      check_val("load_read", {31'd0, saw_rd}, 32'd1);
      check_val("load_addr", rd_addr, addr >> 2);
    end else begin
      check_val("store_write", {31'd0, saw_wr}, 32'd1);
      check_val("store_addr", wr_addr, addr >> 2);
      check_val("store_wdata", wr_data, exp_word);
    end
    @(negedge clk);
    check_val("idle_ready", {31'd0, req_ready}, 32'd1);
    check_val("idle_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check_val("idle_rdata", resp_rdata, 32'd0);
    if (wr && !exp_err) check_val("mem_word", tb_mem[addr >> 2], ref_mem[addr >> 2]);
    $display("[TB] %s f3=%0d addr=0x%08h wdata=0x%08h -> err=%0d rdata=0x%08h lat=%0d",
             wr ? "ST" : "LD", f3, addr, wd, err_got, got_rdata, got_lat);
  endtask

  initial begin
    logic [31:0] r, a;
    bit e;
    int l, mw0, rv_cnt, resp_n1, resp_n2;
    logic [31:0] nw;
    bit acc2;

    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      tb_mem[i] = r;
      ref_mem[i] = r;
    end

    @(negedge clk);
    check_val("rst_outputs", {26'd0, req_ready, resp_valid, resp_err, MemRead, MemWrite, 1'b0}, 32'd0);
    check_val("rst_addr_wdata", address | write_data | resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Directed sequence
    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, r);
    do_req(0, 3'd2, 32'h10, 32'h0, r);      check_val("lw_readback", r, 32'hDEADBEEF);
    do_req(1, 3'd0, 32'h11, 32'h123456A5, r);
    check_val("sb_word", tb_mem[4], 32'hDEADA5EF);
    do_req(0, 3'd0, 32'h13, 32'h0, r);      check_val("lb_13", r, 32'hFFFFFFDE);
    do_req(0, 3'd4, 32'h13, 32'h0, r);      check_val("lbu_13", r, 32'h000000DE);
    do_req(0, 3'd1, 32'h12, 32'h0, r);      check_val("lh_12", r, 32'hFFFFDEAD);
    do_req(0, 3'd5, 32'h10, 32'h0, r);      check_val("lhu_10", r, 32'h0000A5EF);
    do_req(0, 3'd0, 32'h11, 32'h0, r);      check_val("lb_11", r, 32'hFFFFFFA5);
    do_req(0, 3'd2, 32'h12, 32'h0, r);
    do_req(1, 3'd1, 32'h11, 32'h0, r);
    do_req(0, 3'd2, 32'h100, 32'h0, r);
    do_req(0, 3'd3, 32'h10, 32'h0, r);
    do_req(0, 3'd2, 32'hFC, 32'h0, r);

    // Reset in the RMW_RD cycle of SH 0x10
    tb_mem[4] = 32'h11111111;
    ref_mem[4] = 32'h11111111;
    @(negedge clk);
    mw0 = mw_edges;
    rv_cnt = 0;
    req_write = 1; req_funct3 = 3'd1; req_addr = 32'h10; req_wdata = 32'h0000FFFF; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    #2;
    check_val("rmw_rd_read", {31'd0, MemRead}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("rst_mid_outputs", {29'd0, MemRead, MemWrite, req_ready}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (resp_valid || MemWrite) rv_cnt++;
    end
    rst = 1'b0;
    @(negedge clk);
    if (resp_valid) rv_cnt++;
    check_val("rst_no_activity", rv_cnt, 0);
    check_val("rst_no_write_edge", mw_edges - mw0, 0);
    check_val("rst_word_kept", tb_mem[4], 32'h11111111);
    check_val("rst_ready_back", {31'd0, req_ready}, 32'd1);
    $display("[TB] reset during SH 0x10 RMW: word=0x%08h", tb_mem[4]);

    // Back-to-back: LW 0x10 then SW 0x14 with req_valid held high
    ref_model(0, 3'd2, 32'h10, 32'h0, e, a, l, nw);
    ref_model(1, 3'd2, 32'h14, 32'hCAFEF00D, e, r, l, nw);
    @(negedge clk);
    req_write = 0; req_funct3 = 3'd2; req_addr = 32'h10; req_valid = 1;
    @(posedge clk);
    #1 req_write = 1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
    acc2 = 0; rv_cnt = 0; resp_n1 = 0; resp_n2 = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n <= 3) check_val($sformatf("b2b_ready_c%0d", n), {31'd0, req_ready}, (n == 3) ? 32'd1 : 32'd0);
      if (resp_valid) begin
        rv_cnt++;
        if (resp_n1 == 0) begin resp_n1 = n; check_val("b2b_lw_data", resp_rdata, a); end
        else resp_n2 = n;
      end
      if (req_ready && req_valid && !acc2) begin
        acc2 = 1;
        @(posedge clk);
        #1 req_valid = 0;
      end
    end
    check_val("b2b_pulses", rv_cnt, 2);
    check_val("b2b_first_resp", resp_n1, 2);
    check_val("b2b_spacing", resp_n2 - resp_n1, 3);
    check_val("b2b_sw_word", tb_mem[5], ref_mem[5]);
    $display("[TB] back-to-back LW/SW: resp at cycles %0d and %0d", resp_n1, resp_n2);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      bit wr;
      logic [2:0] f3;
      wr = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, DEPTH * 4 - 1));
      else a = 32'($urandom_range(0, DEPTH * 4 + 32));
      if ($urandom_range(0, 1) == 0) a = a & ~(32'd1 << f3[1:0]) & ~32'(f3[1]) & ~32'(f3[1] << 1);
      do_req(wr, f3, a, $urandom, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
